major_cycle_sequencer: RTL

- Timing generator that drives the instruction-fetch/indirect control decoder and the execute decoder of the PDP-8 core.
- Steps the CPU through its major cycles: FETCH, optional AUTO1/AUTO2 (auto-increment indirect), optional IND, and EXEC.
- Emits one-clock-wide ck/stb phase pulses, which downstream logic ANDs with instruction-type decodes.
- Also provides run/halt and single-step control.

---
 rtl/major_cycle_sequencer.sv | 76 +++++++
 1 files changed

// File: rtl/major_cycle_sequencer.sv
// major_cycle_sequencer: PDP-8 major-cycle phase pulse generator with run/step control
module major_cycle_sequencer #(
  parameter int EXEC_STEPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       instIsIND,
  input  logic       instIsPPIND,
  output logic       ckFetch,
  output logic       stbFetch,
  output logic       stbFetch2,
  output logic       ckAuto1,
  output logic       stbAuto1,
  output logic       ckAuto2,
  output logic       stbAuto2,
  output logic       ckInd,
  output logic       stbInd,
  output logic       ckExec,
  output logic       stbExec,
  output logic [2:0] execStep,
  output logic       instDone,
  output logic       running
);
  typedef enum logic [3:0] {IDLE, F0, F1, F2, A1C, A1S, A2C, A2S, IC, IS, EC, ES} state_t;
  state_t state_q, state_d;
  logic [2:0] exec_q, exec_d;
  logic last;
  assign last = exec_q == 3'(EXEC_STEPS - 1);
  always_comb begin
    state_d = state_q;
    exec_d = exec_q;
    case (state_q)
      IDLE: state_d = (run || step) ? F0 : IDLE;
      F0: state_d = F1;
      F1: state_d = F2;
      F2: state_d = instIsPPIND ? A1C : instIsIND ? IC : EC;
      A1C: state_d = A1S;
      A1S: state_d = A2C;
      A2C: state_d = A2S;
      A2S: state_d = IC;
      IC: state_d = IS;
      IS: state_d = EC;
      EC: state_d = ES;
      ES: begin
        state_d = last ? (run ? F0 : IDLE) : EC;
        exec_d = last ? 3'd0 : exec_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      exec_q <= 3'd0;
    end else begin
      state_q <= state_d;
      exec_q <= exec_d;
    end
  end
  assign ckFetch = state_q == F0;
  assign stbFetch = state_q == F1;
  assign stbFetch2 = state_q == F2;
  assign ckAuto1 = state_q == A1C;
  assign stbAuto1 = state_q == A1S;
  assign ckAuto2 = state_q == A2C;
  assign stbAuto2 = state_q == A2S;
  assign ckInd = state_q == IC;
  assign stbInd = state_q == IS;
  assign ckExec = state_q == EC;
  assign stbExec = state_q == ES;
  assign execStep = exec_q;
  assign instDone = (state_q == ES) && last;
  assign running = state_q != IDLE;
endmodule
